// File: rtl/timer_avalon32_bridge_if.sv
// Bus bundle for the 32-bit Avalon-MM to 16-bit timer bridge.
// The slave modport is the bridge's view; master is the CPU-plus-timer side.
interface timer_avalon32_bridge_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] s_address;
  logic              s_read;
  logic              s_write;
  logic [31:0]       s_writedata;
  logic [3:0]        s_byteenable;
  logic              s_waitrequest;
  logic [31:0]       s_readdata;
  logic              s_readdatavalid;

  logic [3:0]        m_address;
  logic              m_chipselect;
  logic              m_write_n;
  logic [15:0]       m_writedata;
  logic [15:0]       m_readdata;

  modport slave (
    input  s_address, s_read, s_write, s_writedata, s_byteenable, m_readdata,
    output s_waitrequest, s_readdata, s_readdatavalid,
           m_address, m_chipselect, m_write_n, m_writedata
  );

  modport master (
    output s_address, s_read, s_write, s_writedata, s_byteenable, m_readdata,
    input  s_waitrequest, s_readdata, s_readdatavalid,
           m_address, m_chipselect, m_write_n, m_writedata
  );
endinterface

// File: rtl/timer_avalon32_bridge.sv
// Splits 32-bit Avalon-MM word accesses into two 16-bit timer accesses (lo then hi)
// and reassembles read results from the timer's one-cycle-latency readdata.
module timer_avalon32_bridge #(
  parameter int          ADDR_W    = 3,
  parameter int unsigned NUM_WORDS = 5
) (
  input logic                    clk,
  input logic                    reset_n,
  timer_avalon32_bridge_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_LO  = 3'd1;
  localparam logic [2:0] WR_HI  = 3'd2;
  localparam logic [2:0] RD_LO  = 3'd3;
  localparam logic [2:0] RD_HI  = 3'd4;
  localparam logic [2:0] RD_CAP = 3'd5;
  localparam logic [2:0] RESP   = 3'd6;

  logic [2:0]  state;
  logic [3:0]  hi_addr_q;
  logic [15:0] hi_data_q;
  logic [1:0]  hi_be_q;
  logic [15:0] lo_q;

  logic        in_range;
  logic [3:0]  lo_addr_in;
  logic [3:0]  hi_addr_in;

  assign in_range   = (32'(bus.s_address) < NUM_WORDS);
  assign lo_addr_in = 4'({bus.s_address, 1'b0});
  assign hi_addr_in = 4'({bus.s_address, 1'b1});

  assign bus.s_waitrequest = (state != IDLE);

  // Downstream outputs are registered and loaded with the values of the state being entered,
  // so each state's outputs are stable for its whole cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      hi_addr_q           <= '0;
      hi_data_q           <= '0;
      hi_be_q             <= '0;
      lo_q                <= '0;
      bus.s_readdata      <= '0;
      bus.s_readdatavalid <= 1'b0;
      bus.m_address       <= '0;
      bus.m_chipselect    <= 1'b0;
      bus.m_write_n       <= 1'b1;
      bus.m_writedata     <= '0;
    end else begin
      bus.s_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          bus.m_chipselect <= 1'b0;
          bus.m_write_n    <= 1'b1;
          if (bus.s_read || bus.s_write) begin
            hi_addr_q <= hi_addr_in;
            hi_data_q <= bus.s_writedata[31:16];
            hi_be_q   <= bus.s_byteenable[3:2];
          end
          // A simultaneous read is dropped in favour of the write.
          if (bus.s_write) begin
            if (in_range) begin
              state            <= WR_LO;
              bus.m_address    <= lo_addr_in;
              bus.m_writedata  <= bus.s_writedata[15:0];
              bus.m_chipselect <= |bus.s_byteenable[1:0];
              bus.m_write_n    <= ~|bus.s_byteenable[1:0];
            end
          end else if (bus.s_read) begin
            if (in_range) begin
              state            <= RD_LO;
              bus.m_address    <= lo_addr_in;
              bus.m_chipselect <= 1'b1;
            end else begin
              state               <= RESP;
              bus.s_readdata      <= '0;
              bus.s_readdatavalid <= 1'b1;
            end
          end
        end
        WR_LO: begin
          state            <= WR_HI;
          bus.m_address    <= hi_addr_q;
          bus.m_writedata  <= hi_data_q;
          bus.m_chipselect <= |hi_be_q;
          bus.m_write_n    <= ~|hi_be_q;
        end
        WR_HI: begin
          state            <= IDLE;
          bus.m_chipselect <= 1'b0;
          bus.m_write_n    <= 1'b1;
        end
        RD_LO: begin
          state         <= RD_HI;
          bus.m_address <= hi_addr_q;
        end
        // m_readdata now reflects the lo address issued one cycle earlier.
        RD_HI: begin
          state <= RD_CAP;
          lo_q  <= bus.m_readdata;
        end
        RD_CAP: begin
          state               <= RESP;
          bus.s_readdata      <= {bus.m_readdata, lo_q};
          bus.s_readdatavalid <= 1'b1;
          bus.m_chipselect    <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state            <= IDLE;
          bus.m_chipselect <= 1'b0;
          bus.m_write_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_avalon32_bridge.sv
// Randomized self-checking bench for timer_avalon32_bridge with a behavioural timer
// and a word-level reference model.
module tb_timer_avalon32_bridge;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  timer_avalon32_bridge_if #(.ADDR_W(3)) bus ();

  timer_avalon32_bridge #(.ADDR_W(3), .NUM_WORDS(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Timer slave: 16 halfword registers, registered readdata of the previous address.
  logic [15:0] timer_mem [0:15];
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_data = '0;

  always @(posedge clk) begin
    if (load_en) timer_mem[load_addr] <= load_data;
    else if (bus.m_chipselect && !bus.m_write_n) timer_mem[bus.m_address] <= bus.m_writedata;
    bus.m_readdata <= timer_mem[bus.m_address];
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] ref_word [0:4];
  logic [19:0] exp_w [$];

  int          obs_wait;
  int          obs_lat;
  int          obs_valid_cnt;
  logic [31:0] obs_rdata;
  bit          obs_cs [1:8];
  bit          obs_cs_any;
  logic [19:0] obs_w [$];

  // Reference model: a word write updates each halfword whose byte pair is enabled.
  task automatic model_write(input int w, input logic [31:0] wd, input logic [3:0] be);
    exp_w.delete();
    if (w < 5) begin
      if (be[1:0] != 2'b00) begin
        ref_word[w][15:0] = wd[15:0];
        exp_w.push_back({4'(2 * w), wd[15:0]});
      end
      if (be[3:2] != 2'b00) begin
        ref_word[w][31:16] = wd[31:16];
        exp_w.push_back({4'(2 * w + 1), wd[31:16]});
      end
    end
  endtask

  function automatic logic [31:0] model_read(input int w);
    return (w < 5) ? ref_word[w] : 32'h0;
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [2:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    bus.s_address    = a;
    bus.s_read       = rd;
    bus.s_write      = wr;
    bus.s_writedata  = wd;
    bus.s_byteenable = be;
    @(posedge clk);
    #1;
    bus.s_read  = 1'b0;
    bus.s_write = 1'b0;
    obs_wait = 0; obs_lat = 0; obs_valid_cnt = 0; obs_rdata = '0; obs_cs_any = 1'b0;
    obs_w.delete();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      obs_cs[c] = bus.m_chipselect;
      if (bus.m_chipselect) obs_cs_any = 1'b1;
      if (bus.s_waitrequest) obs_wait++;
      if (bus.s_readdatavalid) begin
        obs_valid_cnt++;
        if (obs_lat == 0) begin
          obs_lat   = c;
          obs_rdata = bus.s_readdata;
        end
      end
      if (bus.m_chipselect && !bus.m_write_n) obs_w.push_back({bus.m_address, bus.m_writedata});
    end
  endtask

  task automatic preload();
    for (int w = 0; w < 5; w++) ref_word[w] = $urandom;
    ref_word[4] = 32'hDEAD_BEEF;
    for (int h = 0; h < 16; h++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 4'(h);
      load_data = (h < 10) ? ((h % 2 == 0) ? ref_word[h / 2][15:0] : ref_word[h / 2][31:16]) : 16'h0;
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.s_waitrequest !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_waitrequest got %b want 0", bus.s_waitrequest); end
    n_checks++; if (bus.s_readdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_readdata got %h want 0", bus.s_readdata); end
    n_checks++; if (bus.s_readdatavalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", bus.s_readdatavalid); end
    n_checks++; if (bus.m_address !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_m_address got %h want 0", bus.m_address); end
    n_checks++; if (bus.m_chipselect !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_chipselect got %b want 0", bus.m_chipselect); end
    n_checks++; if (bus.m_write_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_write_n got %b want 1", bus.m_write_n); end
    n_checks++; if (bus.m_writedata !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_writedata got %h want 0", bus.m_writedata); end
  endtask

  task automatic test_write_full();
    model_write(1, 32'h0001_86A0, 4'hF);
    issue(1'b0, 1'b1, 3'd1, 32'h0001_86A0, 4'hF);
    n_checks++; if (obs_wait != 2) begin n_fail++; $display("[TB] FAIL wr_full_wait got %0d want 2", obs_wait); end
    n_checks++; if (obs_w.size() != 2) begin n_fail++; $display("[TB] FAIL wr_full_count got %0d want 2", obs_w.size()); end
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      n_checks++; if (obs_w[i] !== exp_w[i]) begin n_fail++; $display("[TB] FAIL wr_full_beat%0d got %h want %h", i, obs_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_write_hi_only();
    model_write(0, 32'h000B_0000, 4'b1100);
    issue(1'b0, 1'b1, 3'd0, 32'h000B_0000, 4'b1100);
    n_checks++; if (obs_cs[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_hi_lo_cs got %b want 0", obs_cs[1]); end
    n_checks++; if (obs_w.size() != 1) begin n_fail++; $display("[TB] FAIL wr_hi_count got %0d want 1", obs_w.size()); end
    if (obs_w.size() >= 1) begin
      n_checks++; if (obs_w[0] !== {4'd1, 16'h000B}) begin n_fail++; $display("[TB] FAIL wr_hi_beat got %h want %h", obs_w[0], {4'd1, 16'h000B}); end
    end
  endtask

  task automatic test_read_snap();
    issue(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
    n_checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL rd_snap_data got %h want deadbeef", obs_rdata); end
    n_checks++; if (obs_lat != 4) begin n_fail++; $display("[TB] FAIL rd_snap_latency got %0d want 4", obs_lat); end
    n_checks++; if (obs_valid_cnt != 1) begin n_fail++; $display("[TB] FAIL rd_snap_pulses got %0d want 1", obs_valid_cnt); end
  endtask

  task automatic test_read_oor();
    issue(1'b1, 1'b0, 3'd7, 32'h0, 4'hF);
    n_checks++; if (obs_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rd_oor_data got %h want 0", obs_rdata); end
    n_checks++; if (obs_lat != 1) begin n_fail++; $display("[TB] FAIL rd_oor_latency got %0d want 1", obs_lat); end
    n_checks++; if (obs_cs_any !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_oor_chipselect got %b want 0", obs_cs_any); end
  endtask

  task automatic test_rw_collision();
    logic [31:0] wd;
    wd = $urandom;
    model_write(2, wd, 4'hF);
    issue(1'b1, 1'b1, 3'd2, wd, 4'hF);
    n_checks++; if (obs_valid_cnt != 0) begin n_fail++; $display("[TB] FAIL rw_valid got %0d want 0", obs_valid_cnt); end
    n_checks++; if (obs_w.size() != 2) begin n_fail++; $display("[TB] FAIL rw_count got %0d want 2", obs_w.size()); end
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      n_checks++; if (obs_w[i] !== exp_w[i]) begin n_fail++; $display("[TB] FAIL rw_beat%0d got %h want %h", i, obs_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    int pulses;
    @(negedge clk);
    bus.s_address = 3'd1;
    bus.s_read    = 1'b1;
    @(posedge clk);
    #1;
    bus.s_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.m_address !== 4'd3) begin n_fail++; $display("[TB] FAIL mid_rd_hi_addr got %h want 3", bus.m_address); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.s_readdata !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_reset_readdata got %h want 0", bus.s_readdata); end
    n_checks++; if (bus.m_chipselect !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_cs got %b want 0", bus.m_chipselect); end
    n_checks++; if (bus.m_address !== 4'h0) begin n_fail++; $display("[TB] FAIL mid_reset_addr got %h want 0", bus.m_address); end
    n_checks++; if (bus.s_waitrequest !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_wait got %b want 0", bus.s_waitrequest); end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.s_readdatavalid) pulses++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.s_readdatavalid) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("[TB] FAIL mid_reset_pulses got %0d want 0", pulses); end
    issue(1'b1, 1'b0, 3'd1, 32'h0, 4'h0);
    n_checks++; if (obs_rdata !== model_read(1)) begin n_fail++; $display("[TB] FAIL post_reset_read got %h want %h", obs_rdata, model_read(1)); end
  endtask

  task automatic test_random();
    bit          rd, wr;
    int          w;
    logic [31:0] wd;
    logic [3:0]  be;
    for (int n = 0; n < 40; n++) begin
      w  = $urandom_range(0, 7);
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      wd = $urandom;
      be = 4'($urandom);
      if (wr) begin
        model_write(w, wd, be);
        issue(rd, 1'b1, 3'(w), wd, be);
        n_checks++; if (obs_valid_cnt != 0) begin n_fail++; $display("[TB] FAIL rnd%0d_wr_valid got %0d want 0", n, obs_valid_cnt); end
        n_checks++; if (obs_wait != ((w < 5) ? 2 : 0)) begin n_fail++; $display("[TB] FAIL rnd%0d_wr_wait got %0d want %0d", n, obs_wait, (w < 5) ? 2 : 0); end
        n_checks++; if (obs_w.size() != exp_w.size()) begin n_fail++; $display("[TB] FAIL rnd%0d_wr_count got %0d want %0d", n, obs_w.size(), exp_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
          n_checks++; if (obs_w[i] !== exp_w[i]) begin n_fail++; $display("[TB] FAIL rnd%0d_wr_beat%0d got %h want %h", n, i, obs_w[i], exp_w[i]); end
        end
      end else begin
        issue(1'b1, 1'b0, 3'(w), wd, be);
        n_checks++; if (obs_valid_cnt != 1) begin n_fail++; $display("[TB] FAIL rnd%0d_rd_pulses got %0d want 1", n, obs_valid_cnt); end
        n_checks++; if (obs_lat != ((w < 5) ? 4 : 1)) begin n_fail++; $display("[TB] FAIL rnd%0d_rd_latency got %0d want %0d", n, obs_lat, (w < 5) ? 4 : 1); end
        n_checks++; if (obs_rdata !== model_read(w)) begin n_fail++; $display("[TB] FAIL rnd%0d_rd_data got %h want %h", n, obs_rdata, model_read(w)); end
        n_checks++; if (obs_w.size() != 0) begin n_fail++; $display("[TB] FAIL rnd%0d_rd_writes got %0d want 0", n, obs_w.size()); end
      end
    end
  endtask

  initial begin
    bus.s_address    = '0;
    bus.s_read       = 1'b0;
    bus.s_write      = 1'b0;
    bus.s_writedata  = '0;
    bus.s_byteenable = '0;
    preload();
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_write_full();
    test_write_hi_only();
    test_read_snap();
    test_read_oor();
    test_rw_collision();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
